// File: rtl/w_mem_banked_sram_ctrl.sv
// Banked weight-memory controller: N_BANKS single-port SRAMs, write/read request channels, in-order read responses.
// Optional define W_MEM_RD_BYPASS_EN forwards bank Q straight to rd_data when the response FIFO is empty.
module w_mem_banked_sram_ctrl #(
  parameter int N_LANES     = 4,
  parameter int DATA_W      = 8,
  parameter int BANK_ADDR_W = 10,
  parameter int N_BANKS     = 2,
  parameter int RSP_DEPTH   = 2,
  parameter int LANE_W      = $clog2(N_LANES),
  parameter int ADDR_W      = BANK_ADDR_W + LANE_W + $clog2(N_BANKS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [N_LANES*DATA_W-1:0]   wr_data,
  input  logic [N_LANES-1:0]          wr_lane_en,
  input  logic                        rd_valid,
  output logic                        rd_ready,
  input  logic [ADDR_W-1:0]           rd_addr,
  output logic                        rd_data_valid,
  input  logic                        rd_data_ready,
  output logic [N_LANES*DATA_W-1:0]   rd_data,
  output logic [15:0]                 conflict_cnt
);

  localparam int BANK_W = $clog2(N_BANKS);
  localparam int BSEL_W = (BANK_W > 0) ? BANK_W : 1;
  localparam int ROW_W  = N_LANES * DATA_W;
  localparam int PTR_W  = $clog2(RSP_DEPTH);
  localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
  localparam int OUT_W  = CNT_W + 1;

  logic [BSEL_W-1:0]      wr_bank, rd_bank, q_bank;
  logic [BANK_ADDR_W-1:0] wr_row, rd_row;
  logic                   wr_fire, wr_access, rd_fire, same_bank, conflict;
  logic                   credit_ok, q_pend, push, pop, consume, bypass;
  logic [OUT_W-1:0]       outstanding;
  logic [ROW_W-1:0]       bwen, cur_q;
  logic [ROW_W-1:0]       bank_q [N_BANKS];
  logic [ROW_W-1:0]       fifo_mem [RSP_DEPTH];
  logic [PTR_W-1:0]       wptr, rptr;
  logic [CNT_W-1:0]       count;

  // Address decode
  if (BANK_W > 0) begin : g_bank_field
    assign wr_bank = wr_addr[ADDR_W-1 -: BSEL_W];
    assign rd_bank = rd_addr[ADDR_W-1 -: BSEL_W];
  end else begin : g_single_bank
    assign wr_bank = '0;
    assign rd_bank = '0;
  end

  if (LANE_W > 0) begin : g_lane_bits
    logic unused_lane_bits;
    assign unused_lane_bits = ^{wr_addr[LANE_W-1:0], rd_addr[LANE_W-1:0]};
  end

  assign wr_row = wr_addr[BANK_ADDR_W+LANE_W-1:LANE_W];
  assign rd_row = rd_addr[BANK_ADDR_W+LANE_W-1:LANE_W];

  // Handshakes and arbitration: a write always owns its bank
  assign same_bank = (wr_bank == rd_bank);
  assign wr_ready  = !reset;
  assign wr_fire   = wr_valid && wr_ready;
  assign wr_access = wr_fire && (|wr_lane_en);
  assign conflict  = rd_valid && wr_valid && same_bank;

  // A response leaving this cycle frees its slot; that keeps back-to-back reads at full rate.
  assign consume = rd_data_valid && rd_data_ready;
  always_comb begin
    outstanding = OUT_W'(count) + OUT_W'(q_pend) - OUT_W'(consume);
  end
  assign credit_ok = (outstanding < OUT_W'(RSP_DEPTH));
  assign rd_ready  = !reset && credit_ok && !(wr_valid && same_bank);
  assign rd_fire   = rd_valid && rd_ready;

  // Active-low per-bit write mask
  always_comb begin
    bwen = '1;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      if (wr_lane_en[i]) bwen[i*DATA_W +: DATA_W] = '0;
    end
  end

  // Single-port SRAM macros, 1-cycle read latency, contents not reset
  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    logic                   wsel, rsel, csn, wen;
    logic [BANK_ADDR_W-1:0] a;
    logic [ROW_W-1:0]       q;
    logic [ROW_W-1:0]       mem [2**BANK_ADDR_W];

    assign wsel = wr_access && (wr_bank == BSEL_W'(b));
    assign rsel = rd_fire && (rd_bank == BSEL_W'(b));
    assign csn  = !(wsel || rsel);
    assign wen  = !wsel;
    assign a    = wsel ? wr_row : rd_row;

    always_ff @(posedge clk) begin
      if (!csn) begin
        if (!wen) mem[a] <= (mem[a] & bwen) | (wr_data & ~bwen);
        else      q      <= mem[a];
      end
    end

    assign bank_q[b] = q;
  end

  assign cur_q = bank_q[q_bank];

  // Response path
`ifdef W_MEM_RD_BYPASS_EN
  assign bypass        = q_pend && (count == '0) && rd_data_ready;
  assign rd_data_valid = (count != '0) || q_pend;
  always_comb begin
    rd_data = '0;
    if (count != '0)  rd_data = fifo_mem[rptr];
    else if (q_pend)  rd_data = cur_q;
  end
`else
  assign bypass        = 1'b0;
  assign rd_data_valid = (count != '0);
  always_comb begin
    rd_data = '0;
    if (count != '0) rd_data = fifo_mem[rptr];
  end
`endif

  assign push = q_pend && !bypass;
  assign pop  = (count != '0) && rd_data_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_pend       <= 1'b0;
      q_bank       <= '0;
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      conflict_cnt <= '0;
    end else begin
      q_pend <= rd_fire;
      if (rd_fire) q_bank <= rd_bank;
      if (push) wptr <= (wptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : wptr + PTR_W'(1);
      if (pop)  rptr <= (rptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (conflict && (conflict_cnt != '1)) conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr] <= cur_q;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (count == CNT_W'(RSP_DEPTH))));

endmodule
